// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: frames SPI byte pulses into register write strobes.
// Frame = header byte {opcode[7:6], addr[5:0]} followed by big-endian words.
// Optional per-word checksum byte enabled by defining SPI_CKSUM_EN.
module spi_cmd_decoder #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              csn,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              reg_we,
  output logic [5:0]        reg_addr,
  output logic [DATA_W-1:0] reg_data,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int         BYTES = DATA_W / 8;
  localparam logic [2:0] LAST  = 3'(BYTES - 1);

`ifdef SPI_CKSUM_EN
  typedef enum logic [1:0] {IDLE, DATA, CKSUM, DISCARD} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, DISCARD} state_t;
`endif

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [7:0]        hdr_reg, hdr_next;
  logic [5:0]        addr_reg, addr_next;
`ifdef SPI_CKSUM_EN
  logic [7:0]        cksum_reg, cksum_next;
`endif

  logic              we_next;
  logic [5:0]        reg_addr_next;
  logic [DATA_W-1:0] reg_data_next;
  logic [7:0]        err_next;
  logic              err_inc;
  logic              word_done;
  logic [DATA_W-1:0] shifted;

  assign shifted   = (shift_reg << 8) | DATA_W'(byte_in);
  assign word_done = byte_valid && (cnt_reg == LAST);
  assign err_next  = (err_inc && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      hdr_reg   <= '0;
      addr_reg  <= '0;
`ifdef SPI_CKSUM_EN
      cksum_reg <= '0;
`endif
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      err_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      hdr_reg   <= hdr_next;
      addr_reg  <= addr_next;
`ifdef SPI_CKSUM_EN
      cksum_reg <= cksum_next;
`endif
      reg_we    <= we_next;
      reg_addr  <= reg_addr_next;
      reg_data  <= reg_data_next;
      err_cnt   <= err_next;
      busy      <= (state_next != IDLE);
    end
  end

  // Next-state, write issue and error detection
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    hdr_next      = hdr_reg;
    addr_next     = addr_reg;
`ifdef SPI_CKSUM_EN
    cksum_next    = cksum_reg;
`endif
    we_next       = 1'b0;
    reg_addr_next = reg_addr;
    reg_data_next = reg_data;
    err_inc       = 1'b0;

    case (state_reg)
      IDLE: begin
        // Bytes seen while deselected are dropped here
        if (!csn && byte_valid) begin
          hdr_next   = byte_in;
          addr_next  = byte_in[5:0];
          cnt_next   = '0;
          shift_next = '0;
`ifdef SPI_CKSUM_EN
          cksum_next = byte_in;
`endif
          case (byte_in[7:6])
            2'b01, 2'b10: state_next = DATA;
            2'b11: begin
              err_inc    = 1'b1;
              state_next = DISCARD;
            end
            default: state_next = DISCARD;
          endcase
        end
      end

      DATA: begin
        if (byte_valid) begin
          shift_next = shifted;
          cnt_next   = cnt_reg + 3'd1;
`ifdef SPI_CKSUM_EN
          cksum_next = cksum_reg ^ byte_in;
          if (word_done) begin
            cnt_next   = '0;
            state_next = CKSUM;
          end
`else
          if (word_done) begin
            cnt_next      = '0;
            we_next       = 1'b1;
            reg_addr_next = addr_reg;
            reg_data_next = shifted;
            if (hdr_reg[7]) addr_next  = addr_reg + 6'd1;
            else            state_next = DISCARD;
          end
`endif
        end
        if (csn) begin
          state_next = IDLE;
`ifdef SPI_CKSUM_EN
          // A word is never complete here: its checksum is still owed
          if (byte_valid || cnt_reg != 0 || !hdr_reg[7]) err_inc = 1'b1;
`else
          // Single frames sitting in DATA never wrote; bursts are fine on a word boundary
          if (!word_done && (byte_valid || cnt_reg != 0 || !hdr_reg[7])) err_inc = 1'b1;
`endif
        end
      end

`ifdef SPI_CKSUM_EN
      CKSUM: begin
        if (byte_valid) begin
          if (byte_in == cksum_reg) begin
            we_next       = 1'b1;
            reg_addr_next = addr_reg;
            reg_data_next = shift_reg;
            cksum_next    = hdr_reg;
            if (hdr_reg[7]) begin
              addr_next  = addr_reg + 6'd1;
              state_next = DATA;
            end else begin
              state_next = DISCARD;
            end
          end else begin
            err_inc    = 1'b1;
            state_next = DISCARD;
          end
        end
        if (csn) begin
          state_next = IDLE;
          if (!byte_valid) err_inc = 1'b1;
        end
      end
`endif

      DISCARD: begin
        if (csn) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed testbench for spi_cmd_decoder (DATA_W = 16).
// Builds with or without SPI_CKSUM_EN; the checksum scenarios run only when defined.
module tb_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        csn = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [15:0] reg_data;
  logic [7:0]  err_cnt;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0]  wq_addr[$];
  logic [15:0] wq_data[$];

  spi_cmd_decoder #(.DATA_W(16)) dut (
    .clk(clk), .rstn(rstn), .csn(csn), .byte_in(byte_in), .byte_valid(byte_valid),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every write strobe away from the active edge
  always @(negedge clk) begin
    if (reg_we === 1'b1) begin
      wq_addr.push_back(reg_addr);
      wq_data.push_back(reg_data);
      $display("write addr=%0d data=0x%04h", reg_addr, reg_data);
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic frame_start();
    csn = 1'b0;
    cycle();
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    cycle();
    byte_valid = 1'b0;
  endtask

  task automatic frame_end();
    csn = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cycle();
    vectors++;
    if (reg_we !== 1'b0 || reg_addr !== 6'd0 || reg_data !== 16'h0 || err_cnt !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: we=%b addr=%0d data=%h err=%0d busy=%b, want all 0", reg_we, reg_addr, reg_data, err_cnt, busy);
    end
    rstn = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    clear_q();
    frame_start();
    send_byte(8'h45);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
    send_byte(8'h12);
    send_byte(8'h34);
    vectors++;
    if (reg_we !== 1'b1 || reg_addr !== 6'd5 || reg_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL single_latency: we=%b addr=%0d data=%h want 1/5/1234", reg_we, reg_addr, reg_data);
    end
    frame_end();
    vectors++;
    if (wq_addr.size() != 1 || err_cnt !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_count: writes=%0d err=%0d busy=%b want 1/0/0", wq_addr.size(), err_cnt, busy);
    end
    $display("single write: writes=%0d err=%0d", wq_addr.size(), err_cnt);
  endtask

  task automatic test_burst(input logic [7:0] hdr, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [5:0] a0, input logic [5:0] a1);
    clear_q();
    frame_start();
    send_byte(hdr);
    send_byte(w0[15:8]); send_byte(w0[7:0]);
    send_byte(w1[15:8]); send_byte(w1[7:0]);
    frame_end();
    vectors++;
    if (wq_addr.size() != 2) begin
      miscompares++;
      $display("FAIL burst_count hdr=%h: got %0d writes want 2", hdr, wq_addr.size());
    end else begin
      vectors++;
      if (wq_addr[0] !== a0 || wq_data[0] !== w0 || wq_addr[1] !== a1 || wq_data[1] !== w1) begin
        miscompares++;
        $display("FAIL burst_data hdr=%h: got %0d=%h %0d=%h want %0d=%h %0d=%h", hdr,
                 wq_addr[0], wq_data[0], wq_addr[1], wq_data[1], a0, w0, a1, w1);
      end
    end
    vectors++;
    if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL burst_err hdr=%h: got %0d want 0", hdr, err_cnt); end
    $display("burst hdr=%h: writes=%0d", hdr, wq_addr.size());
  endtask

  task automatic test_errors();
    clear_q();
    frame_start();
    send_byte(8'hC0); send_byte(8'hFF); send_byte(8'hFF);
    frame_end();
    vectors++;
    if (wq_addr.size() != 0 || err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL reserved_op: writes=%0d err=%0d want 0/1", wq_addr.size(), err_cnt);
    end
    frame_start();
    send_byte(8'h45); send_byte(8'h12);
    frame_end();
    vectors++;
    if (wq_addr.size() != 0 || err_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL partial_word: writes=%0d err=%0d want 0/2", wq_addr.size(), err_cnt);
    end
    frame_start();
    send_byte(8'h47);
    frame_end();
    vectors++;
    if (wq_addr.size() != 0 || err_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL header_only_single: writes=%0d err=%0d want 0/3", wq_addr.size(), err_cnt);
    end
    $display("errors: err=%0d", err_cnt);
  endtask

  task automatic test_benign();
    clear_q();
    // NOP, zero-word burst, and a single write with trailing bytes: no errors
    frame_start(); send_byte(8'h00); send_byte(8'h55); frame_end();
    frame_start(); send_byte(8'h80); frame_end();
    frame_start(); send_byte(8'h41); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); frame_end();
    // Bytes while deselected are ignored
    send_byte(8'h45); send_byte(8'h12); send_byte(8'h34);
    cycle();
    vectors++;
    if (wq_addr.size() != 1 || err_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL benign_frames: writes=%0d err=%0d want 1/3", wq_addr.size(), err_cnt);
    end else begin
      vectors++;
      if (wq_addr[0] !== 6'd1 || wq_data[0] !== 16'hAABB) begin
        miscompares++;
        $display("FAIL extra_bytes: got %0d=%h want 1=aabb", wq_addr[0], wq_data[0]);
      end
    end
    $display("benign frames: writes=%0d err=%0d", wq_addr.size(), err_cnt);
  endtask

  task automatic test_same_cycle();
    clear_q();
    frame_start();
    send_byte(8'h47); send_byte(8'h56);
    byte_in = 8'h78; byte_valid = 1'b1; csn = 1'b1;
    cycle();
    byte_valid = 1'b0;
    vectors++;
    if (reg_we !== 1'b1 || reg_addr !== 6'd7 || reg_data !== 16'h5678) begin
      miscompares++;
      $display("FAIL same_cycle_write: we=%b addr=%0d data=%h want 1/7/5678", reg_we, reg_addr, reg_data);
    end
    cycle();
    vectors++;
    if (busy !== 1'b0 || err_cnt !== 8'd3 || wq_addr.size() != 1) begin
      miscompares++;
      $display("FAIL same_cycle_after: busy=%b err=%0d writes=%0d want 0/3/1", busy, err_cnt, wq_addr.size());
    end
    $display("same cycle: err=%0d", err_cnt);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      csn = 1'b0; cycle();
      send_byte(8'hC0);
      csn = 1'b1; cycle();
    end
    cycle();
    vectors++;
    if (err_cnt !== 8'd255) begin miscompares++; $display("FAIL err_saturate: got %0d want 255", err_cnt); end
    $display("saturate: err=%0d", err_cnt);
  endtask

  task automatic test_mid_reset();
    clear_q();
    frame_start();
    send_byte(8'h45); send_byte(8'h12);
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if (reg_we !== 1'b0 || reg_addr !== 6'd0 || reg_data !== 16'h0 || err_cnt !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: we=%b addr=%0d data=%h err=%0d busy=%b want all 0", reg_we, reg_addr, reg_data, err_cnt, busy);
    end
    csn = 1'b1;
    cycle(); cycle();
    rstn = 1'b1;
    cycle();
    frame_start();
    send_byte(8'h46); send_byte(8'h00); send_byte(8'h07);
    frame_end();
    vectors++;
    if (wq_addr.size() != 1) begin
      miscompares++;
      $display("FAIL reset_writes: got %0d writes want 1", wq_addr.size());
    end else begin
      vectors++;
      if (wq_addr[0] !== 6'd6 || wq_data[0] !== 16'h0007) begin
        miscompares++;
        $display("FAIL reset_data: got %0d=%h want 6=0007", wq_addr[0], wq_data[0]);
      end
    end
    $display("mid reset: writes=%0d", wq_addr.size());
  endtask

`ifdef SPI_CKSUM_EN
  task automatic test_cksum();
    clear_q();
    frame_start();
    send_byte(8'h45); send_byte(8'h12); send_byte(8'h34);
    vectors++;
    if (reg_we !== 1'b0) begin miscompares++; $display("FAIL cksum_early: we=%b want 0", reg_we); end
    send_byte(8'h63);
    vectors++;
    if (reg_we !== 1'b1 || reg_addr !== 6'd5 || reg_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL cksum_write: we=%b addr=%0d data=%h want 1/5/1234", reg_we, reg_addr, reg_data);
    end
    frame_end();
    frame_start();
    send_byte(8'h45); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    frame_end();
    vectors++;
    if (wq_addr.size() != 1 || err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL cksum_bad: writes=%0d err=%0d want 1/1", wq_addr.size(), err_cnt);
    end
    clear_q();
    frame_start();
    send_byte(8'h8A); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEC);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h8B);
    frame_end();
    vectors++;
    if (wq_addr.size() != 2 || err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL cksum_burst: writes=%0d err=%0d want 2/1", wq_addr.size(), err_cnt);
    end else begin
      vectors++;
      if (wq_addr[0] !== 6'd10 || wq_data[0] !== 16'hABCD || wq_addr[1] !== 6'd11 || wq_data[1] !== 16'h0001) begin
        miscompares++;
        $display("FAIL cksum_burst_data: got %0d=%h %0d=%h want 10=abcd 11=0001",
                 wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
      end
    end
    $display("checksum: err=%0d", err_cnt);
  endtask
`endif

  initial begin
    test_reset();
`ifdef SPI_CKSUM_EN
    test_cksum();
`else
    test_single();
    test_burst(8'h8A, 16'hABCD, 16'h0001, 6'd10, 6'd11);
    test_burst(8'hBF, 16'h1111, 16'h2222, 6'd63, 6'd0);
    test_errors();
    test_benign();
    test_same_cycle();
    test_saturate();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Byte-stream command decoder between the SPI slave and the synth register space. It consumes the byte pulses that `spi_slave` produces on each completed SPI transfer and frames them into register writes. Each frame is one header byte (opcode + address) followed by big-endian data words. It emits single-cycle register write strobes to the voice/parameter register file and keeps a saturating error count.

## Interface
- `DATA_W`, 16: register data width in bits; must be a multiple of 8, range 8–32. `BYTES = DATA_W/8`.
- `clk`  input  1  system clock (100 MHz domain).
- `rstn`  input  1  asynchronous active-low reset.
- `csn`  input  1  SPI chip select, already synchronised to `clk`. Low means a frame is in progress.
- `byte_in`  input  8  received byte; valid only with `byte_valid`.
- `byte_valid`  input  1  one-cycle pulse per received byte.
- `reg_we`  output  1  one-cycle write strobe.
- `reg_addr`  output  6  write address; held between strobes.
- `reg_data`  output  DATA_W  write data; held between strobes.
- `err_cnt`  output  8  saturating frame error count.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- Header byte: `[7:6]` is the opcode, `[5:0]` is the start address.
  - Opcode 00: NOP. Go to DISCARD, no error.
  - Opcode 01: single write.
  - Opcode 10: burst write.
  - Opcode 11: reserved. Increment `err_cnt`, go to DISCARD.
- States:
  - IDLE: wait for the header byte.
  - DATA: shift in `BYTES` bytes, MSB first.
  - CKSUM: only present when the checksum macro is defined.
  - DISCARD: ignore bytes until `csn` goes high.
- When a word completes, issue a write.
  - Single write: then go to DISCARD. Extra bytes are ignored without error.
  - Burst write: increment the address by 1 modulo 64 (63 wraps to 0), clear the byte count, stay in DATA.
- `csn` high in any state returns the FSM to IDLE next cycle.
  - If this happens in DATA/CKSUM with a partial word (byte count ≠ 0, or checksum pending), increment `err_cnt` and do not write.
  - A single-write frame that ends after the header alone is an error.
  - A burst frame that ends at a word boundary, including zero words, is not an error.
- `byte_valid` while `csn` is high is ignored.
- `err_cnt` saturates at 255 and clears only on reset.

## Timing
- Reset values:
  - `reg_we` = 0, `reg_addr` = 0, `reg_data` = 0, `err_cnt` = 0, `busy` = 0.
  - State = IDLE; byte counter and shift register = 0.
- All outputs are registered.
- Write latency: `reg_we`, `reg_addr` and `reg_data` update on the clock edge that samples the final `byte_valid` of a word. `reg_we` is high for exactly one cycle.
- Back-to-back `byte_valid` on consecutive cycles is supported at full rate. Burst writes may then appear every `BYTES` cycles.
- `byte_valid` and `csn` rising in the same cycle: process the byte first. If it completes a word, the write is issued, then the FSM returns to IDLE; no error is counted.
- `busy` rises the cycle after the header byte is accepted. It falls the cycle after `csn` is seen high.
- `rstn` low mid-frame clears everything immediately, asynchronously. No write is issued for the aborted frame.

## Configuration
- `SPI_CKSUM_EN` defined:
  - Each data word is followed by one checksum byte, equal to header XOR all bytes of that word.
  - The write is issued on the edge that samples a matching checksum byte.
  - On mismatch: no write, `err_cnt` +1, go to DISCARD.
- `SPI_CKSUM_EN` undefined: there is no CKSUM state, and the write is issued on the last data byte.

## Test plan
- Single write (DATA_W=16, no checksum): frame 0x45, 0x12, 0x34, then `csn` high → one `reg_we` pulse with addr 5, data 0x1234; `err_cnt` = 0.
- Burst write: frame 0x8A, 0xAB, 0xCD, 0x00, 0x01 → writes addr 10 = 0xABCD, then addr 11 = 0x0001. Burst 0xBF, 0x11, 0x11, 0x22, 0x22 → writes addr 63 = 0x1111, then addr 0 = 0x2222.
- Errors:
  - Header 0xC0, 0xFF, 0xFF → no write, `err_cnt` = 1.
  - 0x45, 0x12, then `csn` high → no write, `err_cnt` = 2.
  - 300 error frames → `err_cnt` = 255.
- Same-cycle boundary: last data byte's `byte_valid` coincides with `csn` rising → write issued, `err_cnt` unchanged, `busy` low one cycle later.
- Reset: assert `rstn` low after 0x45, 0x12, release, then send 0x46, 0x00, 0x07 → only write addr 6 = 0x0007. All outputs read 0 during reset.
- `SPI_CKSUM_EN`:
  - 0x45, 0x12, 0x34, 0x63 → write addr 5 = 0x1234.
  - 0x45, 0x12, 0x34, 0x00 → no write, `err_cnt` = 1.
